// File: rtl/share_decoder.sv
// share_decoder: share-serial unmasking of one Boolean-masked word into its plain value.
// Latency: last share accepted at edge t -> out_valid in cycle t+1 (t+2 with SHARE_DECODER_INREG_EN).
// Backpressure: out_valid/out_data hold until out_ready; in_ready stays 0 for that whole time.
//
// Ports:
//   C          clock, rising edge
//   R          synchronous active-high reset
//   in_valid   share on in_share is valid
//   in_ready   decoder accepts a share this cycle (registered state decode)
//   in_share   current share, arriving in index order 0..NSHARES-1
//   out_valid  out_data holds a recombined word
//   out_ready  consumer accepts out_data
//   out_data   recombined word, forced to 0 while out_valid=0
//
// Optional build macro SHARE_DECODER_INREG_EN: adds a WIDTH-bit input register
// (plus first/last flags) in front of the accumulator, and a FLUSH state that
// drains it. Port list is the same in both builds.
module share_decoder #(
  parameter int WIDTH   = 8,
  parameter int NSHARES = 3
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_share,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int            CW       = (NSHARES > 1) ? $clog2(NSHARES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSHARES - 1);

`ifdef SHARE_DECODER_INREG_EN
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    OUT   = 2'd1,
    FLUSH = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ACC = 2'd0,
    OUT = 2'd1
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              accept;
  logic              cnt_last;

`ifdef SHARE_DECODER_INREG_EN
  // Glitch barrier: the share bus never feeds the accumulator XOR directly.
  logic [WIDTH-1:0]  inr_dat_q, inr_dat_d;
  logic              inr_vld_q, inr_vld_d;
  logic              inr_first_q, inr_first_d;
  logic              inr_last_q, inr_last_d;
`endif

  // Only a state decode, so in_ready has no combinational path from out_ready.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  // Partial accumulator contents must never leak onto the output bus.
  assign out_data  = acc_q & {WIDTH{out_valid}};

  assign accept   = in_valid & in_ready;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    if (accept) begin
      cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
    end

`ifdef SHARE_DECODER_INREG_EN
    inr_vld_d   = accept;
    inr_dat_d   = accept ? in_share : inr_dat_q;
    inr_first_d = accept ? (cnt_q == '0) : inr_first_q;
    inr_last_d  = accept ? cnt_last : inr_last_q;

    // First share of a word is loaded, never XORed with the stale word.
    if (inr_vld_q) begin
      acc_d = inr_first_q ? inr_dat_q : (acc_q ^ inr_dat_q);
    end

    case (state_q)
      ACC:     if (accept && cnt_last) state_d = FLUSH;
      FLUSH:   if (inr_vld_q && inr_last_q) state_d = OUT;
      OUT:     if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
`else
    if (accept) begin
      acc_d = (cnt_q == '0) ? in_share : (acc_q ^ in_share);
    end

    case (state_q)
      ACC:     if (accept && cnt_last) state_d = OUT;
      OUT:     if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
`endif
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
`ifdef SHARE_DECODER_INREG_EN
      inr_dat_q   <= '0;
      inr_vld_q   <= 1'b0;
      inr_first_q <= 1'b0;
      inr_last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`ifdef SHARE_DECODER_INREG_EN
      inr_dat_q   <= inr_dat_d;
      inr_vld_q   <= inr_vld_d;
      inr_first_q <= inr_first_d;
      inr_last_q  <= inr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_share_decoder.sv
// tb_share_decoder: drives share_decoder with directed and random traffic and
// compares every cycle against a word-level reference model.
// Model: shares collected in a queue, output word = XOR of the queue, fixed latency.
module tb_share_decoder;

  localparam int WIDTH   = 8;
  localparam int NSHARES = 3;
`ifdef SHARE_DECODER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       C = 1'b0;
  logic       R;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_share;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  share_decoder #(.WIDTH(WIDTH), .NSHARES(NSHARES)) dut (
    .C        (C),
    .R        (R),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_share (in_share),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 C = ~C;

  // Reference model state
  logic [7:0] m_shares[$];
  logic [7:0] m_word;
  bit         m_pend;
  int         m_wait;

  // Observation bookkeeping for directed scenarios
  int         vcycles;
  logic [7:0] got[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    return !m_pend;
  endfunction

  function automatic bit m_out_valid();
    return m_pend && (m_wait == 0);
  endfunction

  task automatic model_reset();
    m_shares.delete();
    m_word = 8'h00;
    m_pend = 1'b0;
    m_wait = 0;
  endtask

  task automatic model_update(input bit r, input bit v, input logic [7:0] s, input bit ordy);
    bit rdy;
    bit ov;
    rdy = m_in_ready();
    ov  = m_out_valid();
    if (r) begin
      model_reset();
      return;
    end
    if (ov && ordy) m_pend = 1'b0;
    else if (m_pend && m_wait > 0) m_wait--;
    if (v && rdy) begin
      m_shares.push_back(s);
      if (m_shares.size() == NSHARES) begin
        m_word = 8'h00;
        foreach (m_shares[i]) m_word ^= m_shares[i];
        m_shares.delete();
        m_pend = 1'b1;
        m_wait = LAT - 1;
      end
    end
  endtask

  // One clock cycle: check outputs mid-cycle, drive inputs, advance model at the edge.
  task automatic step(input bit r, input bit v, input logic [7:0] s, input bit ordy);
    @(negedge C);
    check("in_ready", in_ready, m_in_ready());
    check("out_valid", out_valid, m_out_valid());
    check("out_data", out_data, m_out_valid() ? m_word : 8'h00);
    if (out_valid === 1'b1) begin
      vcycles++;
      if (ordy) got.push_back(out_data);
    end
    R = r; in_valid = v; in_share = s; out_ready = ordy;
    @(posedge C);
    model_update(r, v, s, ordy);
  endtask

  // Offer a share until the model says it is taken (bounded).
  task automatic send(input logic [7:0] s, input bit ordy);
    int n;
    bit taken;
    n = 0;
    do begin
      taken = m_in_ready();
      step(1'b0, 1'b1, s, ordy);
      n++;
    end while (!taken && n < 50);
    check("send_accept", taken, 1);
  endtask

  task automatic clear_obs();
    vcycles = 0;
    got.delete();
  endtask

  initial begin
    logic [7:0] basic[3];
    basic[0] = 8'h5A; basic[1] = 8'h3C; basic[2] = 8'hA5;

    R = 1'b1; in_valid = 1'b0; in_share = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge C);
    model_reset();

    // Basic word, back-to-back shares; first step also checks reset state.
    clear_obs();
    foreach (basic[i]) send(basic[i], 1'b1);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("basic_vcycles", vcycles, 1);
    check("basic_count", got.size(), 1);
    if (got.size() > 0) check("basic_word", got[0], 8'hC3);

    // Gaps between shares, then 4 cycles of backpressure with a 4th share offered.
    clear_obs();
    foreach (basic[i]) begin
      send(basic[i], 1'b0);
      if (i < 2) repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
    end
    repeat (LAT - 1 + 4) step(1'b0, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("bp_vcycles", vcycles, 5);
    check("bp_count", got.size(), 1);
    if (got.size() > 0) check("bp_word", got[0], 8'hC3);

    // Back-to-back words; the next word also proves 0x77 was not consumed.
    clear_obs();
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h04, 1'b1);
    send(8'hFF, 1'b1); send(8'hFF, 1'b1); send(8'h0F, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_count", got.size(), 2);
    if (got.size() > 1) begin
      check("b2b_word_a", got[0], 8'h07);
      check("b2b_word_b", got[1], 8'h0F);
    end

    // Reset mid-word discards the partial word.
    clear_obs();
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    send(8'h0F, 1'b1); send(8'hF0, 1'b1); send(8'h00, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rstmid_vcycles", vcycles, 1);
    check("rstmid_count", got.size(), 1);
    if (got.size() > 0) check("rstmid_word", got[0], 8'hFF);

    // Reset while a word is being presented under backpressure.
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0);
    repeat (LAT - 1) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge C);
    check("rstout_out_valid", out_valid, 0);
    check("rstout_out_data", out_data, 8'h00);
    check("rstout_in_ready", in_ready, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic with occasional resets.
    repeat (3000) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 70,
           8'($urandom),
           $urandom_range(0, 99) < 60);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
